d_ff_pipeline: RTL and testbench
================================

D_FF_PIPELINE -- requirements
Module: d_ff_pipeline

Interface
REQ-001 Parameter: WIDTH, default 8, data bits per stage; SHALL be at least 1.
REQ-002 Parameter: DEPTH, default 3, number of register stages; SHALL be at least 1.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low; sampled on the clk rising edge.
REQ-005 Port: in_valid  input  1  upstream offers in_data this cycle.
REQ-006 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-007 Port: in_data  input  WIDTH  upstream data word.
REQ-008 Port: out_valid  output  1  last stage holds a valid word.
REQ-009 Port: out_ready  input  1  downstream consumes out_data this cycle.
REQ-010 Port: out_data  output  WIDTH  content of the last stage.
REQ-011 Port: flush  input  1  synchronous discard of all stored words.
REQ-012 Port: count  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-013 Stages SHALL be indexed 0 (input) to DEPTH-1 (output); each stage holds one data register and one valid bit.
REQ-014 A transfer SHALL occur on an edge where valid and ready are both high on the same side; in_data SHALL be captured only on an input transfer.
REQ-015 The last stage SHALL advance when it is empty or out_ready=1; stage i<DEPTH-1 SHALL advance when it is empty or stage i+1 advances.
REQ-016 in_ready SHALL equal the stage-0 advance condition and be combinational from out_ready, valid bits and flush.
REQ-017 When stage i advances, stage i+1 SHALL load stage i's data and valid bit; stage 0 SHALL load in_data with valid=in_valid.
REQ-018 A stage that does not advance SHALL hold its data and valid bit unchanged; bubbles SHALL collapse when downstream stalls.
REQ-019 Latency with out_ready held high SHALL be exactly DEPTH cycles from input transfer to out_valid=1; throughput SHALL be one word per cycle.
REQ-020 Ordering SHALL be strict FIFO; no word SHALL be duplicated or dropped except by flush or reset.
REQ-021 When full (count=DEPTH) and out_ready=1, the block SHALL accept a new word on the same edge it emits one.
REQ-022 When full and out_ready=0, in_ready SHALL be 0.
REQ-023 count SHALL be registered and equal the number of set valid bits after every edge; its range is 0..DEPTH.
REQ-024 flush=1 SHALL clear all valid bits on that edge, force in_ready=0 and out_valid is unaffected until the edge (the word presented is not consumed, since out_ready is ignored).
REQ-025 flush SHALL take priority over in_valid and out_ready; count SHALL be 0 after the edge.
REQ-026 DEPTH=1 SHALL behave as a single-entry buffer with in_ready = !out_valid | out_ready.

Reset
REQ-027 rst_n=0 at an edge SHALL clear all valid bits and set count to 0, overriding flush and all transfers.
REQ-028 During and after reset: out_valid=0, count=0, in_ready=1 once rst_n=1 and flush=0.
REQ-029 Reset asserted mid-stream SHALL discard all stored words; no partial transfer SHALL complete on that edge.

Configuration
REQ-030 Macro D_FF_PIPELINE_DATA_CLR_EN: when defined, all data registers SHALL clear to 0 on reset and on flush, making out_data=0 whenever count=0 after reset/flush.
REQ-031 Without D_FF_PIPELINE_DATA_CLR_EN, data registers SHALL have no reset or flush term; only valid bits and count are cleared, and out_data is don't-care while out_valid=0.

Verification (WIDTH=8, DEPTH=3)
REQ-032 Hold rst_n=0 for 2 cycles -> out_valid=0, count=0, in_ready=1 after release.
REQ-033 out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> each appears on out_data 3 cycles after its acceptance, in order, with out_valid continuous.
REQ-034 out_ready=0, offer 0xA1..0xA4 -> three accepted, count=3, in_ready=0; raise out_ready -> 0xA1 emitted and 0xA4 accepted on the same edge.
REQ-035 out_ready=0, push 0x55, idle 2 cycles, push 0x66 -> count=2, out_data=0x55, and the next two words on out_data are 0x55 then 0x66.
REQ-036 count=2 with in_valid=1, pulse flush -> next cycle count=0, out_valid=0, input not accepted; out_data=0x00 only with D_FF_PIPELINE_DATA_CLR_EN.
REQ-037 Assert rst_n=0 with count=3 and in_valid=1, out_ready=1 -> next cycle count=0, out_valid=0, no word emitted or accepted on that edge.

Source files
------------

// File: rtl/d_ff_pipeline.sv
// Elastic register pipeline: DEPTH stages with valid/ready handshake, bubble collapse and flush.
// Optional macro D_FF_PIPELINE_DATA_CLR_EN clears data registers on reset and flush.
module d_ff_pipeline #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 3
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [WIDTH-1:0]               in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [WIDTH-1:0]               out_data,
   input  logic                           flush,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] r_valid;
   logic [WIDTH-1:0] r_data [DEPTH];
   logic [CW-1:0]    r_count;
   logic [DEPTH-1:0] w_adv;
   logic             w_in_xfer;
   logic             w_out_xfer;

   // A stage stalls only when it and every stage downstream of it is full and the output is blocked.
   always_comb begin
      logic w_full;
      w_full = 1'b1;
      w_adv  = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         w_full   = w_full & r_valid[i];
         w_adv[i] = out_ready | ~w_full;
      end
   end

   assign in_ready   = w_adv[0] & ~flush;
   assign w_in_xfer  = in_valid & in_ready;
   assign w_out_xfer = r_valid[DEPTH-1] & out_ready & ~flush;

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         r_valid <= '0;
         r_count <= '0;
      end else begin
         if (w_adv[0]) r_valid[0] <= in_valid;
         for (int i = 1; i < int'(DEPTH); i++) begin
            if (w_adv[i]) r_valid[i] <= r_valid[i-1];
         end
         r_count <= r_count + CW'(w_in_xfer) - CW'(w_out_xfer);
      end
   end

`ifdef D_FF_PIPELINE_DATA_CLR_EN
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         for (int i = 0; i < int'(DEPTH); i++) r_data[i] <= '0;
      end else begin
         if (w_in_xfer) r_data[0] <= in_data;
         for (int i = 1; i < int'(DEPTH); i++) begin
            if (w_adv[i]) r_data[i] <= r_data[i-1];
         end
      end
   end
`else
   // Data path carries no reset; contents are meaningful only under the matching valid bit.
   always_ff @(posedge clk) begin
      if (w_in_xfer) r_data[0] <= in_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
         if (w_adv[i]) r_data[i] <= r_data[i-1];
      end
   end
`endif

   assign out_valid = r_valid[DEPTH-1];
   assign out_data  = r_data[DEPTH-1];
   assign count     = r_count;

endmodule

// File: tb/tb_d_ff_pipeline.sv
// Scoreboard bench for d_ff_pipeline (WIDTH=8, DEPTH=3): accepted words are queued and
// compared in order as the DUT emits them; count and in_ready are checked every cycle.
module tb_d_ff_pipeline;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 3;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             flush;
   logic [1:0]       count;

   typedef struct packed {
      logic [WIDTH-1:0] d;
      logic [31:0]      c;
   } sb_t;

   sb_t         q[$];
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   logic [31:0] cyc = 0;
   logic        lat_chk = 1'b0;

   d_ff_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .flush     (flush),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: drive at negedge, predict transfers, clock, check registered state.
   task automatic step(input logic rn, input logic iv, input logic [WIDTH-1:0] id,
                       input logic ordy, input logic fl);
      logic exp_rdy;
      logic out_x;
      logic in_x;
      sb_t  e;
      rst_n     = rn;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      #1;
      exp_rdy = !fl && (ordy || q.size() != int'(DEPTH));
      if (cyc != 0) check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
      out_x = rn && !fl && ordy && (out_valid === 1'b1);
      in_x  = rn && iv && exp_rdy;
      if (out_x) begin
         if (q.size() == 0) begin
            check_eq("underflow", 32'(out_valid), 32'(0));
         end else begin
            e = q.pop_front();
            check_eq("out_data", 32'(out_data), 32'(e.d));
            if (lat_chk) check_eq("latency", cyc - e.c, 32'(DEPTH));
         end
      end
      if (!rn || fl) q.delete();
      else if (in_x) q.push_back('{d: id, c: cyc});
      @(posedge clk);
      cyc++;
      #1;
      check_eq("count", 32'(count), 32'(q.size()));
      if (q.size() == 0) check_eq("out_valid_empty", 32'(out_valid), 32'(0));
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
      @(negedge clk);

      // Reset held for two cycles.
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      rst_n = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
      #1;
      check_eq("rst_out_valid", 32'(out_valid), 32'(0));
      check_eq("rst_count", 32'(count), 32'(0));
      check_eq("rst_in_ready", 32'(in_ready), 32'(1));
      #1;

      // Streaming with out_ready high: fixed latency, back-to-back output.
      lat_chk = 1'b1;
      step(1'b1, 1'b1, 8'h11, 1'b1, 1'b0);
      step(1'b1, 1'b1, 8'h22, 1'b1, 1'b0);
      step(1'b1, 1'b1, 8'h33, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      lat_chk = 1'b0;
      check_eq("stream_drained", 32'(q.size()), 32'(0));

      // Fill to full, then emit and accept on the same edge.
      step(1'b1, 1'b1, 8'hA1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'hA2, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'hA3, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'hA4, 1'b0, 1'b0);
      in_valid = 1'b1; in_data = 8'hA4; out_ready = 1'b0;
      #1;
      check_eq("full_count", 32'(count), 32'(DEPTH));
      check_eq("full_in_ready", 32'(in_ready), 32'(0));
      check_eq("full_head", 32'(out_data), 32'(8'hA1));
      step(1'b1, 1'b1, 8'hA4, 1'b1, 1'b0);
      check_eq("full_swap_count", 32'(count), 32'(DEPTH));
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

      // Bubble collapse while stalled.
      step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'h66, 1'b0, 1'b0);
      check_eq("bubble_count", 32'(count), 32'(2));
      check_eq("bubble_valid", 32'(out_valid), 32'(1));
      check_eq("bubble_data", 32'(out_data), 32'(8'h55));
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

      // Flush with input offered.
      step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'h88, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'h99, 1'b0, 1'b1);
      check_eq("flush_count", 32'(count), 32'(0));
      check_eq("flush_valid", 32'(out_valid), 32'(0));
`ifdef D_FF_PIPELINE_DATA_CLR_EN
      check_eq("flush_data_clr", 32'(out_data), 32'(0));
`endif
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

      // Reset mid-stream while full with both handshakes active.
      step(1'b1, 1'b1, 8'hC1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'hC2, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
      check_eq("pre_rst_count", 32'(count), 32'(DEPTH));
      step(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
      check_eq("midrst_count", 32'(count), 32'(0));
      check_eq("midrst_valid", 32'(out_valid), 32'(0));
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(99) != 0),
              1'($urandom_range(1)),
              8'($urandom),
              ($urandom_range(9) < 7),
              ($urandom_range(31) == 0));
      end

      // Bounded drain.
      for (int i = 0; i < 50 && q.size() != 0; i++) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      check_eq("drain_empty", 32'(q.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
